// File: rtl/game2048_pkg.sv
// Purpose: shared state enum, tile constants, LFSR taps and board type for the 2048 datapath blocks.
// Latency: none, declarations only.
// Backpressure: not applicable.
package game2048_pkg;

  typedef enum logic [2:0] {IDLE, COUNT, SELECT, PLACE, DONE} spawn_state_t;

  localparam int unsigned BOARD_N   = 4;
  localparam int unsigned TILE_W    = 12;
  localparam int unsigned TILE_TWO  = 2;
  localparam int unsigned TILE_FOUR = 4;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Default-geometry board; blocks built with other N/W derive the same shape locally.
  typedef logic [BOARD_N-1:0][BOARD_N-1:0][TILE_W-1:0] board_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tile_spawner_if.sv
// Purpose: request/response bundle between the move engine, the tile spawner and the board register.
// Latency: none, wiring only.
// Backpressure: none; the requester watches busy/done and the spawner ignores start while busy.
interface tile_spawner_if #(
  parameter int N = 4,
  parameter int W = 12
);
  logic                           start;
  logic [1:0]                     num_tiles;
  logic [N-1:0][N-1:0][W-1:0]     board_in;
  logic [N-1:0][N-1:0][W-1:0]     board_out;
  logic                           busy;
  logic                           done;
  logic [1:0]                     placed;
  logic                           full;

  modport master (
    output start, num_tiles, board_in,
    input  board_out, busy, done, placed, full
  );

  modport slave (
    input  start, num_tiles, board_in,
    output board_out, busy, done, placed, full
  );
endinterface

// File: rtl/lfsr16.sv
// Purpose: free-running 16-bit Fibonacci LFSR shared by the spawner, game-over and animation blocks.
// Latency: new value every cycle; reset loads seed (zero seed forced to 1 to avoid lock-up).
// Backpressure: none, never stalls.
module lfsr16
  import game2048_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;

  // Advance every cycle; reset reloads the seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/tile_spawner.sv
// Purpose: place 1 or 2 random 2/4 tiles into uniformly chosen empty cells of a captured board.
// Latency: per tile N*N count + 1 select + (k+1) place cycles, then DONE; full board reports after N*N.
// Backpressure: start ignored unless IDLE; a full board is reported via full with done, never stalls.
module tile_spawner
  import game2048_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 12,
  parameter int unsigned FOUR_LOG2 = 3,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input logic           clk,
  input logic           rst,
  tile_spawner_if.slave sp
);

  localparam int unsigned   CELLS = N * N;
  localparam int unsigned   IW    = $clog2(CELLS + 1);
  localparam int unsigned   CW    = $clog2(CELLS);
  localparam logic [IW-1:0] LAST  = IW'(CELLS - 1);

  spawn_state_t            state_q, state_d;
  logic [CELLS-1:0][W-1:0] cells_q, cells_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           hit_q, hit_d;
  logic [IW-1:0]           target_q, target_d;
  logic [W-1:0]            val_q, val_d;
  logic                    two_q, two_d;
  logic [1:0]              placed_q, placed_d;
  logic                    full_q, full_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic [15:0]             rnd;
  logic [CW-1:0]           sel;
  logic                    cell_empty;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .out  (rnd)
  );

  // Cell i = row*N + col is exactly the flat packed layout of the board.
  assign sel        = idx_q[CW-1:0];
  assign cell_empty = (cells_q[sel] == '0);

  // Next-state and datapath: one cell examined per cycle in COUNT and PLACE.
  always_comb begin
    state_d  = state_q;
    cells_d  = cells_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    target_d = target_q;
    val_d    = val_q;
    two_d    = two_q;
    placed_d = placed_q;
    full_d   = full_q;
    // done trails the DONE state by one cycle; busy covers that done cycle too.
    done_d   = (state_q == DONE);
    busy_d   = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (sp.start) begin
          cells_d  = sp.board_in;
          two_d    = (sp.num_tiles >= 2'd2);
          placed_d = '0;
          full_d   = 1'b0;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        cnt_d = cnt_q + IW'(cell_empty);
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          idx_d = '0;
          if (cnt_d == '0) begin
            full_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SELECT;
          end
        end
      end
      SELECT: begin
        // Scale the LFSR into [0, cnt) without a divider: (rnd * cnt) >> 16.
        target_d = IW'(({{IW{1'b0}}, rnd} * {{16{1'b0}}, cnt_q}) >> 16);
        val_d    = (rnd[FOUR_LOG2-1:0] == '0) ? W'(TILE_FOUR) : W'(TILE_TWO);
        idx_d    = '0;
        hit_d    = '0;
        state_d  = PLACE;
      end
      PLACE: begin
        idx_d = idx_q + IW'(1);
        if (cell_empty) begin
          hit_d = hit_q + IW'(1);
          // target < cnt and the board is frozen since COUNT, so this always hits.
          if (hit_q == target_q) begin
            cells_d[sel] = val_q;
            placed_d     = placed_q + 2'd1;
            idx_d        = '0;
            cnt_d        = '0;
            state_d      = (two_q && (placed_q == 2'd0)) ? COUNT : DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cells_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      hit_q    <= '0;
      target_q <= '0;
      val_q    <= '0;
      two_q    <= 1'b0;
      placed_q <= '0;
      full_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cells_q  <= cells_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      target_q <= target_d;
      val_q    <= val_d;
      two_q    <= two_d;
      placed_q <= placed_d;
      full_q   <= full_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign sp.board_out = cells_q;
  assign sp.busy      = busy_q;
  assign sp.done      = done_q;
  assign sp.placed    = placed_q;
  assign sp.full      = full_q;

endmodule

// File: doc/tile_spawner.md
Name: tile_spawner

Overview:
- Parametrised successor to the single-tile random placer for the 2048 game.
- On a start request it captures the board, counts empty cells and selects one uniformly from those empty cells using an LFSR-scaled index.
- It writes a 2 or a 4 with programmable odds, and can place 1 or 2 tiles per request (2 for new-game setup).
- Sits between the move/merge engine and the board register; reports a full board instead of stalling.

Parameters:
- N, 4, board side; board holds N*N cells.
- W, 12, tile value width in bits; tile values are stored as literals (2, 4, ...).
- FOUR_LOG2, 3, a spawned tile is 4 with probability 1/2^FOUR_LOG2, otherwise 2.
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE
- num_tiles  in  2  tiles to place, sampled with start; 0 is treated as 1, 3 is treated as 2
- board_in  in  W x [N-1:0][N-1:0]  board to update, sampled with start
- board_out  out  W x [N-1:0][N-1:0]  working board, registered
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse, request complete
- placed  out  2  tiles actually placed, valid with done
- full  out  1  set with done if any requested tile found no empty cell

Behaviour:
- Reset: synchronous and active-high. On rst, state=IDLE, board_out=all 0, busy=0, done=0, placed=0, full=0, LFSR=SEED. A reset mid-operation aborts the request with no done pulse.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It is free-running and advances every cycle, including in IDLE.
- Cell index: i = row*N + col, scanned in ascending i.
- IDLE:
  - start=1 loads board_in into board_out, latches num_tiles and clears the placed counter.
  - Next state is COUNT.
  - start in any other state is ignored.
- COUNT:
  - Exactly N*N cycles, one cell per cycle.
  - cnt (width $clog2(N*N+1)) accumulates cells of board_out equal to 0.
  - After the last cell: if cnt==0, set full=1 and go to DONE; otherwise go to SELECT.
- SELECT (1 cycle):
  - target = (lfsr[15:0] * cnt) >> 16, so 0 <= target < cnt.
  - val = 4 if lfsr[FOUR_LOG2-1:0]==0, else 2. Both values are sampled from the same LFSR state.
- PLACE:
  - Scans cells from i=0 at one cell per cycle, counting empties.
  - On the (target)-th empty cell (0-based), write val to that cell and increment placed.
  - Then go to COUNT again if placed < requested, else to DONE.
  - Duration is k+1 cycles, where k is the index of the chosen cell.
- DONE (1 cycle): done=1, busy=1; next state is IDLE. placed and full hold until the next accepted start.
- Board contract: board_out changes only on the load in IDLE and on single-cell writes in PLACE. A nonzero cell is never overwritten.
- Latency, counting the start-sampling edge as edge 0:
  - done rises after edge N*N + 1 + (k+1) + 1 for a 1-tile request.
  - done rises after edge N*N + 1 for a full board (17 for N=4).
- Second tile: it sees the board including the first tile. If none is left empty, placed=1 and full=1.
- Width rules: cnt and scan index are $clog2(N*N+1) bits. The product is 16 + cnt-width bits.

Decomposition:
- Shared package game2048_pkg holds:
  - spawn_state_t enum {IDLE, COUNT, SELECT, PLACE, DONE}
  - TILE_TWO and TILE_FOUR constants
  - LFSR_TAPS constant
  - the board typedef parametrised by N and W
- Sub-module lfsr16 (clk, rst, seed, out[15:0]) holds the free-running generator, so it can be reused by the game-over and animation blocks.

Test Plan:
- Full board (all cells 16'h..02-style nonzero, N=4), start, num_tiles=1 -> done after edge 17, full=1, placed=0, board_out==board_in.
- Single empty cell at [2][1], start, num_tiles=1 -> board_out[2][1] in {2,4}, all other cells unchanged, placed=1, full=0, done exactly 1 cycle wide.
- Empty board, num_tiles=2 -> exactly two nonzero cells, both in {2,4}, placed=2, full=0; repeat for 200 seeds/runs and confirm every cell index is hit.
- One empty cell, num_tiles=2 -> that cell filled, placed=1, full=1.
- start pulsed during COUNT and PLACE -> ignored, with exactly one done; rst asserted mid-PLACE -> next cycle board_out=0, busy=0, no done, and a fresh start completes normally.
- 2000 spawns on an empty board with FOUR_LOG2=3 -> fraction of 4s between 0.08 and 0.17; compare every result against a cycle-accurate reference model with the same SEED.
